// File: rtl/prbs_pkg.sv
// Shared types and per-polynomial constants for the PRBS generator.
package prbs_pkg;

    localparam int S_W = 31;

    typedef enum logic [1:0] {
        PRBS7  = 2'd0,
        PRBS15 = 2'd1,
        PRBS23 = 2'd2,
        PRBS31 = 2'd3
    } prbs_mode_e;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_e;

    localparam logic [4:0] LEN_7  = 5'd7;
    localparam logic [4:0] TAP_7  = 5'd6;
    localparam logic [4:0] LEN_15 = 5'd15;
    localparam logic [4:0] TAP_15 = 5'd14;
    localparam logic [4:0] LEN_23 = 5'd23;
    localparam logic [4:0] TAP_23 = 5'd18;
    localparam logic [4:0] LEN_31 = 5'd31;
    localparam logic [4:0] TAP_31 = 5'd28;

    function automatic logic [4:0] mode_len(input prbs_mode_e m);
        case (m)
            PRBS7:   return LEN_7;
            PRBS15:  return LEN_15;
            PRBS23:  return LEN_23;
            PRBS31:  return LEN_31;
            default: return LEN_7;
        endcase
    endfunction

    function automatic logic [4:0] mode_tap(input prbs_mode_e m);
        case (m)
            PRBS7:   return TAP_7;
            PRBS15:  return TAP_15;
            PRBS23:  return TAP_23;
            PRBS31:  return TAP_31;
            default: return TAP_7;
        endcase
    endfunction

    // Ones in the low n bits; n=31 yields all ones.
    function automatic logic [S_W-1:0] len_mask(input logic [4:0] n);
        return ~({S_W{1'b1}} << n);
    endfunction

endpackage

// File: rtl/prbs_step.sv
// Combinational OUT_W-step Fibonacci LFSR unroll; first bit lands in the MSB.
module prbs_step
    import prbs_pkg::*;
#(
    parameter int OUT_W = 8
) (
    input  logic [S_W-1:0]   s_i,
    input  logic [4:0]       n_i,
    input  logic [4:0]       t_i,
    output logic [OUT_W-1:0] word_o,
    output logic [S_W-1:0]   s_o
);

    logic [S_W-1:0] mask;
    logic [S_W-1:0] s;
    logic           fb;

    always_comb begin
        mask   = len_mask(n_i);
        s      = s_i;
        fb     = 1'b0;
        word_o = '0;
        for (int i = 0; i < OUT_W; i++) begin
            fb                  = s[n_i - 5'd1] ^ s[t_i - 5'd1];
            word_o[OUT_W-1-i]   = fb;
            s                   = {s[S_W-2:0], fb} & mask;
        end
        s_o = s;
    end

endmodule

// File: rtl/prbs_gen.sv
// Multi-polynomial PRBS word generator with seed load, error injection
// and a one-entry valid/ready output buffer.
module prbs_gen
    import prbs_pkg::*;
#(
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             seed_load,
    input  logic [S_W-1:0]   seed,
    input  logic             err_inj,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             seed_fix
);

    logic [S_W-1:0]   s_q, s_d;
    prbs_mode_e       mode_q, mode_d;
    buf_state_e       state_q, state_d;
    logic [OUT_W-1:0] data_q, data_d;
    logic             err_q, err_d;
    logic             fix_q, fix_d;

    logic [OUT_W-1:0] step_word;
    logic [S_W-1:0]   step_s;
    prbs_mode_e       new_mode;
    logic [S_W-1:0]   new_mask;
    logic [S_W-1:0]   seed_m;
    logic             load;

    prbs_step #(.OUT_W(OUT_W)) u_step (
        .s_i    (s_q),
        .n_i    (mode_len(mode_q)),
        .t_i    (mode_tap(mode_q)),
        .word_o (step_word),
        .s_o    (step_s)
    );

    assign new_mode = prbs_mode_e'(mode);
    assign new_mask = len_mask(mode_len(new_mode));
    assign seed_m   = seed & new_mask;

    always_comb begin
        s_d     = s_q;
        mode_d  = mode_q;
        state_d = state_q;
        data_d  = data_q;
        err_d   = err_q | err_inj;
        fix_d   = fix_q;
        load    = 1'b0;
        if (seed_load) begin
            mode_d  = new_mode;
            state_d = EMPTY;
            if (seed_m == '0) begin
                s_d   = new_mask;
                fix_d = 1'b1;
            end else begin
                s_d = seed_m;
            end
        end else begin
            unique case (state_q)
                EMPTY: load = en;
                FULL: begin
                    if (out_ready) begin
                        load = en;
                        if (!en) state_d = EMPTY;
                    end
                end
            endcase
            // A pulse coincident with a load stays pending for the next word.
            if (load) begin
                s_d               = step_s;
                data_d            = step_word;
                data_d[OUT_W-1]   = step_word[OUT_W-1] ^ err_q;
                err_d             = err_inj;
                state_d           = FULL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_q     <= S_W'(7'h7F);
            mode_q  <= PRBS7;
            state_q <= EMPTY;
            data_q  <= '0;
            err_q   <= 1'b0;
            fix_q   <= 1'b0;
        end else begin
            s_q     <= s_d;
            mode_q  <= mode_d;
            state_q <= state_d;
            data_q  <= data_d;
            err_q   <= err_d;
            fix_q   <= fix_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign seed_fix  = fix_q;

endmodule

// File: tb/tb_prbs_gen.sv
// Directed bench for prbs_gen at OUT_W = 8, 1, 7 and 32 against a bit-level LFSR model.
module tb_prbs_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        seed_load;
    logic        err_inj;
    logic [1:0]  mode;
    logic [30:0] seed;
    logic [3:0]  en_v;
    logic [3:0]  rdy_v;
    logic [3:0]  vld;
    logic [3:0]  fix;
    logic [31:0] dat [4];

    logic [7:0]  d8;
    logic [0:0]  d1;
    logic [6:0]  d7;
    logic [31:0] d32;

    int          nvec = 0;
    int          miss = 0;
    logic [30:0] ms [4];
    int          mn;
    int          mt;
    logic [3:0]  flip;
    int          nw [4];

    always #5 clk = ~clk;

    prbs_gen #(.OUT_W(8)) u8 (
        .clk(clk), .reset(reset), .en(en_v[0]), .mode(mode),
        .seed_load(seed_load), .seed(seed), .err_inj(err_inj),
        .out_ready(rdy_v[0]), .out_valid(vld[0]), .out_data(d8),
        .seed_fix(fix[0])
    );
    prbs_gen #(.OUT_W(1)) u1 (
        .clk(clk), .reset(reset), .en(en_v[1]), .mode(mode),
        .seed_load(seed_load), .seed(seed), .err_inj(1'b0),
        .out_ready(rdy_v[1]), .out_valid(vld[1]), .out_data(d1),
        .seed_fix(fix[1])
    );
    prbs_gen #(.OUT_W(7)) u7 (
        .clk(clk), .reset(reset), .en(en_v[2]), .mode(mode),
        .seed_load(seed_load), .seed(seed), .err_inj(1'b0),
        .out_ready(rdy_v[2]), .out_valid(vld[2]), .out_data(d7),
        .seed_fix(fix[2])
    );
    prbs_gen #(.OUT_W(32)) u32 (
        .clk(clk), .reset(reset), .en(en_v[3]), .mode(mode),
        .seed_load(seed_load), .seed(seed), .err_inj(1'b0),
        .out_ready(rdy_v[3]), .out_valid(vld[3]), .out_data(d32),
        .seed_fix(fix[3])
    );

    assign dat[0] = {24'b0, d8};
    assign dat[1] = {31'b0, d1};
    assign dat[2] = {25'b0, d7};
    assign dat[3] = d32;

    function automatic int wid(input int k);
        case (k)
            0:       return 8;
            1:       return 1;
            2:       return 7;
            default: return 32;
        endcase
    endfunction

    function automatic logic [62:0] adv(input logic [30:0] s, input int width,
                                        input int n, input int t);
        logic [31:0] w;
        logic [31:0] m;
        logic        fb;
        m = (32'h1 << n) - 32'h1;
        w = '0;
        for (int i = 0; i < width; i++) begin
            fb = s[n-1] ^ s[t-1];
            w  = {w[30:0], fb};
            s  = {s[29:0], fb} & m[30:0];
        end
        return {w, s};
    endfunction

    function automatic logic [31:0] peek(input int k);
        logic [62:0] r;
        r = adv(ms[k], wid(k), mn, mt);
        return r[62:31];
    endfunction

    task automatic set_mode(input int md);
        case (md)
            0:       begin mn = 7;  mt = 6;  end
            1:       begin mn = 15; mt = 14; end
            2:       begin mn = 23; mt = 18; end
            default: begin mn = 31; mt = 28; end
        endcase
    endtask

    task automatic model_load(input logic [30:0] v);
        for (int k = 0; k < 4; k++) ms[k] = v;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Score every handshake that the coming edge will complete, then advance.
    task automatic cyc();
        logic [62:0] r;
        logic [31:0] e;
        for (int k = 0; k < 4; k++) begin
            if (vld[k] && rdy_v[k]) begin
                r     = adv(ms[k], wid(k), mn, mt);
                ms[k] = r[30:0];
                e     = r[62:31];
                if (flip[k]) begin
                    e[wid(k)-1] = ~e[wid(k)-1];
                    flip[k]     = 1'b0;
                end
                check($sformatf("stream_w%0d", wid(k)), dat[k], e);
                nw[k]++;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        seed_load = 1'b0;
        err_inj   = 1'b0;
        mode      = 2'd0;
        seed      = '0;
        en_v      = 4'b0001;
        rdy_v     = 4'b0001;
        flip      = '0;
        for (int k = 0; k < 4; k++) nw[k] = 0;
        set_mode(0);
        model_load(31'h7F);
        @(negedge clk);
        @(negedge clk);

        check("rst_valid", {31'b0, vld[0]}, 32'd0);
        check("rst_data", dat[0], 32'd0);
        check("rst_fix", {31'b0, fix[0]}, 32'd0);

        reset = 1'b0;
        cyc();
        check("first_valid", {31'b0, vld[0]}, 32'd1);
        check("first_word", dat[0], 32'h02);
        for (int i = 0; i < 130; i++) begin
            if (nw[0] == 1)   check("word1", dat[0], 32'h0C);
            if (nw[0] == 127) check("period_127", dat[0], 32'h02);
            if (nw[0] == 128) check("period_128", dat[0], 32'h0C);
            cyc();
        end

        rdy_v[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", {31'b0, vld[0]}, 32'd1);
            check("stall_data", dat[0], peek(0));
            cyc();
        end
        rdy_v[0] = 1'b1;
        repeat (6) cyc();

        en_v[0] = 1'b0;
        cyc();
        check("en_gap_empty", {31'b0, vld[0]}, 32'd0);
        cyc();
        en_v[0] = 1'b1;
        repeat (8) cyc();

        rdy_v[0]  = 1'b0;
        seed_load = 1'b1;
        mode      = 2'd3;
        seed      = '0;
        cyc();
        seed_load = 1'b0;
        rdy_v[0]  = 1'b1;
        set_mode(3);
        model_load(31'h7FFF_FFFF);
        check("seed_empty", {31'b0, vld[0]}, 32'd0);
        check("seed_fix", {31'b0, fix[0]}, 32'd1);
        cyc();
        check("p31_valid", {31'b0, vld[0]}, 32'd1);
        check("p31_first", dat[0], 32'h00);
        repeat (20) cyc();

        rdy_v[0]  = 1'b0;
        seed_load = 1'b1;
        seed      = 31'h05A5_A5A5;
        cyc();
        seed_load = 1'b0;
        rdy_v[0]  = 1'b1;
        model_load(31'h05A5_A5A5);
        check("reseed_empty", {31'b0, vld[0]}, 32'd0);
        check("fix_sticky", {31'b0, fix[0]}, 32'd1);
        repeat (12) cyc();

        en_v[0] = 1'b0;
        err_inj = 1'b1;
        cyc();
        err_inj = 1'b0;
        flip[0] = 1'b1;
        en_v[0] = 1'b1;
        repeat (12) cyc();

        rdy_v[0] = 1'b0;
        err_inj  = 1'b1;
        cyc();
        err_inj  = 1'b0;
        reset    = 1'b1;
        cyc();
        check("rst2_valid", {31'b0, vld[0]}, 32'd0);
        check("rst2_data", dat[0], 32'd0);
        check("rst2_fix", {31'b0, fix[0]}, 32'd0);
        reset    = 1'b0;
        rdy_v[0] = 1'b1;
        set_mode(0);
        model_load(31'h7F);
        cyc();
        check("rst2_first", dat[0], 32'h02);
        repeat (10) cyc();

        reset = 1'b1;
        en_v  = '0;
        rdy_v = '0;
        cyc();
        reset     = 1'b0;
        seed_load = 1'b1;
        mode      = 2'd1;
        seed      = 31'h0000_1234;
        cyc();
        seed_load = 1'b0;
        set_mode(1);
        model_load(31'h0000_1234);
        for (int k = 0; k < 4; k++) nw[k] = 0;
        for (int i = 0; i < 700; i++) begin
            en_v  = 4'($urandom);
            rdy_v = 4'($urandom);
            cyc();
        end
        for (int k = 0; k < 4; k++)
            check($sformatf("rand_progress_w%0d", wid(k)),
                  {31'b0, nw[k] > 50}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, miss);
        $finish;
    end

endmodule
